// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction memory port, decode/EX redirect inputs and IF/ID outputs.
// The master modport is the fetch unit; the slave modport is the surrounding pipeline/memory.
interface inst_fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        force_jump;
    logic [31:0] next_pc;
    logic        ex_branch_valid;
    logic [31:0] ex_branch_pc;
    logic [31:0] ex_branch_target;
    logic        ex_branch_taken;
    logic        ex_pred_taken;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_branch_taken;
    logic        flush_id;

    modport master (
        output imem_addr, if_inst, if_pc, if_branch_taken, flush_id,
        input  imem_data, stall, force_jump, next_pc,
               ex_branch_valid, ex_branch_pc, ex_branch_target, ex_branch_taken, ex_pred_taken
    );

    modport slave (
        input  imem_addr, if_inst, if_pc, if_branch_taken, flush_id,
        output imem_data, stall, force_jump, next_pc,
               ex_branch_valid, ex_branch_pc, ex_branch_target, ex_branch_taken, ex_pred_taken
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// IF stage + IF/ID register: PC, imem read, 2-bit BHT with tagged BTB branch prediction,
// EX mispredict and decode jump redirects, decode stall.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          BHT_BITS = 6,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input logic         clk,
    input logic         rst,
    inst_fetch_if.master bus
);
    localparam int ENTRIES = 1 << BHT_BITS;
    localparam int TAG_W   = 30 - BHT_BITS;

    logic [31:0] pc_q, pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        if_bt_q, if_bt_d;

    logic [ENTRIES-1:0][1:0] bht_q;
    logic [ENTRIES-1:0]      btb_valid_q;
    logic [TAG_W-1:0]        btb_tag_q    [ENTRIES];
    logic [31:0]             btb_target_q [ENTRIES];

    logic [BHT_BITS-1:0] idx, ex_idx;
    logic [TAG_W-1:0]    tag, ex_tag;
    logic                pred, mispredict, flush;
    logic [31:0]         pred_pc, fix_pc;
    logic [1:0]          ctr, ctr_d;

    // Lookup sees the predictor state before this cycle's EX update.
    assign idx     = pc_q[BHT_BITS+1:2];
    assign tag     = pc_q[31:BHT_BITS+2];
    assign pred    = bht_q[idx][1] & btb_valid_q[idx] & (btb_tag_q[idx] == tag);
    assign pred_pc = pred ? btb_target_q[idx] : pc_q + 32'd4;

    assign mispredict = bus.ex_branch_valid & (bus.ex_branch_taken != bus.ex_pred_taken);
    assign fix_pc     = bus.ex_branch_taken ? bus.ex_branch_target : bus.ex_branch_pc + 32'd4;

    always_comb begin
        pc_d      = pred_pc;
        if_inst_d = bus.imem_data;
        if_pc_d   = pc_q;
        if_bt_d   = pred;
        flush     = 1'b0;
        if (mispredict) begin
            pc_d      = fix_pc;
            if_inst_d = NOP_INST;
            if_pc_d   = fix_pc;
            if_bt_d   = 1'b0;
            flush     = 1'b1;
        end else if (bus.stall) begin
            // A stalled jr may not have its operand yet, so force_jump waits too.
            pc_d      = pc_q;
            if_inst_d = if_inst_q;
            if_pc_d   = if_pc_q;
            if_bt_d   = if_bt_q;
        end else if (bus.force_jump) begin
            pc_d      = bus.next_pc;
            if_inst_d = NOP_INST;
            if_pc_d   = bus.next_pc;
            if_bt_d   = 1'b0;
            flush     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            if_inst_q <= NOP_INST;
            if_pc_q   <= RESET_PC;
            if_bt_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            if_inst_q <= if_inst_d;
            if_pc_q   <= if_pc_d;
            if_bt_q   <= if_bt_d;
        end
    end

    assign ex_idx = bus.ex_branch_pc[BHT_BITS+1:2];
    assign ex_tag = bus.ex_branch_pc[31:BHT_BITS+2];
    assign ctr    = bht_q[ex_idx];
    assign ctr_d  = bus.ex_branch_taken ? ((ctr == 2'b11) ? ctr : ctr + 2'd1)
                                        : ((ctr == 2'b00) ? ctr : ctr - 2'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bht_q       <= {ENTRIES{2'b01}};
            btb_valid_q <= '0;
        end else if (bus.ex_branch_valid) begin
            bht_q[ex_idx] <= ctr_d;
            if (bus.ex_branch_taken) btb_valid_q[ex_idx] <= 1'b1;
        end
    end

    // Tag/target are only read when the valid bit is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (bus.ex_branch_valid && bus.ex_branch_taken) begin
            btb_tag_q[ex_idx]    <= ex_tag;
            btb_target_q[ex_idx] <= bus.ex_branch_target;
        end
    end

    assign bus.imem_addr       = pc_q;
    assign bus.if_inst         = if_inst_q;
    assign bus.if_pc           = if_pc_q;
    assign bus.if_branch_taken = if_bt_q;
    assign bus.flush_id        = flush;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: sequential fetch, stall, jumps, BHT/BTB training,
// mispredict priority, and asynchronous reset.
module tb_inst_fetch_unit;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    inst_fetch_if bus();

    inst_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .BHT_BITS(6),
        .NOP_INST(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Memory model: instruction word = address | 1, so each fetched word is distinguishable from NOP.
    assign bus.imem_data = bus.imem_addr | 32'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic tk, input logic pt);
        bus.ex_branch_valid  = v;
        bus.ex_branch_pc     = pc;
        bus.ex_branch_target = tgt;
        bus.ex_branch_taken  = tk;
        bus.ex_pred_taken    = pt;
    endtask

    task automatic jump(input logic [31:0] tgt);
        bus.force_jump = 1'b1;
        bus.next_pc    = tgt;
        step();
        bus.force_jump = 1'b0;
        bus.next_pc    = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.force_jump = 1'b0;
        bus.next_pc = 32'h0;
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #12;
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_inst", bus.if_inst, 32'h0);
        chk("rst_pc", bus.if_pc, 32'h0);
        chk("rst_bt", {31'h0, bus.if_branch_taken}, 32'h0);
        chk("rst_flush", {31'h0, bus.flush_id}, 32'h0);
        rst = 1'b0;

        // Sequential fetch
        step();
        chk("seq0_pc", bus.if_pc, 32'h0);
        chk("seq0_inst", bus.if_inst, 32'h1);
        chk("seq0_addr", bus.imem_addr, 32'h4);
        step();
        chk("seq1_pc", bus.if_pc, 32'h4);
        chk("seq1_addr", bus.imem_addr, 32'h8);

        // Stall three cycles at pc=8
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", bus.if_pc, 32'h4);
            chk("stall_inst", bus.if_inst, 32'h5);
            chk("stall_addr", bus.imem_addr, 32'h8);
        end
        bus.stall = 1'b0;
        step();
        chk("resume_pc", bus.if_pc, 32'h8);
        chk("resume_inst", bus.if_inst, 32'h9);
        step();
        chk("seq3_pc", bus.if_pc, 32'hc);
        chk("seq3_bt", {31'h0, bus.if_branch_taken}, 32'h0);
        chk("seq3_addr", bus.imem_addr, 32'h10);

        // force_jump under stall is ignored
        bus.stall = 1'b1;
        bus.force_jump = 1'b1;
        bus.next_pc = 32'h100;
        #1;
        chk("fj_stall_flush", {31'h0, bus.flush_id}, 32'h0);
        step();
        chk("fj_stall_addr", bus.imem_addr, 32'h10);
        chk("fj_stall_pc", bus.if_pc, 32'hc);
        bus.stall = 1'b0;
        #1;
        chk("fj_flush", {31'h0, bus.flush_id}, 32'h1);
        step();
        bus.force_jump = 1'b0;
        chk("fj_inst", bus.if_inst, 32'h0);
        chk("fj_pc", bus.if_pc, 32'h100);
        chk("fj_addr", bus.imem_addr, 32'h100);

        // Train branch at 0x10 -> 0x40 taken twice (predicted not-taken each time)
        for (int i = 0; i < 2; i++) begin
            set_ex(1'b1, 32'h10, 32'h40, 1'b1, 1'b0);
            #1;
            chk("train_flush", {31'h0, bus.flush_id}, 32'h1);
            step();
            chk("train_addr", bus.imem_addr, 32'h40);
            chk("train_pc", bus.if_pc, 32'h40);
            chk("train_inst", bus.if_inst, 32'h0);
        end
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        jump(32'h10);
        step();
        chk("pred_bt", {31'h0, bus.if_branch_taken}, 32'h1);
        chk("pred_pc", bus.if_pc, 32'h10);
        chk("pred_inst", bus.if_inst, 32'h11);
        chk("pred_addr", bus.imem_addr, 32'h40);

        // Same index, different tag: no prediction
        jump(32'h110);
        step();
        chk("alias_bt", {31'h0, bus.if_branch_taken}, 32'h0);
        chk("alias_addr", bus.imem_addr, 32'h114);

        // Saturate counter at 0x20 to 3 while stalled (correct predictions, no redirect)
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_ex(1'b1, 32'h20, 32'h60, 1'b1, 1'b1);
            #1;
            chk("sat_flush", {31'h0, bus.flush_id}, 32'h0);
            step();
            chk("sat_pc", bus.if_pc, 32'h110);
        end

        // Mispredict beats force_jump and stall
        set_ex(1'b1, 32'h20, 32'h60, 1'b0, 1'b1);
        bus.force_jump = 1'b1;
        bus.next_pc = 32'h200;
        #1;
        chk("mp_flush", {31'h0, bus.flush_id}, 32'h1);
        step();
        chk("mp_addr", bus.imem_addr, 32'h24);
        chk("mp_pc", bus.if_pc, 32'h24);
        chk("mp_inst", bus.if_inst, 32'h0);
        chk("mp_bt", {31'h0, bus.if_branch_taken}, 32'h0);
        bus.stall = 1'b0;
        bus.force_jump = 1'b0;
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Counter now 2: still predicts taken
        jump(32'h20);
        step();
        chk("ctr2_bt", {31'h0, bus.if_branch_taken}, 32'h1);
        chk("ctr2_addr", bus.imem_addr, 32'h60);
        chk("ctr2_inst", bus.if_inst, 32'h21);

        // One more not-taken: counter 1, no longer predicts
        set_ex(1'b1, 32'h20, 32'h60, 1'b0, 1'b1);
        step();
        chk("nt_addr", bus.imem_addr, 32'h24);
        set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        jump(32'h20);
        step();
        chk("ctr1_bt", {31'h0, bus.if_branch_taken}, 32'h0);
        chk("ctr1_addr", bus.imem_addr, 32'h24);

        // Asynchronous reset mid-cycle while stalled at 0x80
        jump(32'h80);
        bus.stall = 1'b1;
        chk("pre_rst_addr", bus.imem_addr, 32'h80);
        chk("pre_rst_pc", bus.if_pc, 32'h80);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_addr", bus.imem_addr, 32'h0);
        chk("arst_inst", bus.if_inst, 32'h0);
        chk("arst_pc", bus.if_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.stall = 1'b0;

        // Predictor cleared by reset: 0x10 no longer predicted
        jump(32'h10);
        step();
        chk("post_rst_bt", {31'h0, bus.if_branch_taken}, 32'h0);
        chk("post_rst_pc", bus.if_pc, 32'h10);
        chk("post_rst_addr", bus.imem_addr, 32'h14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
